load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: takes load/store requests from the execute stage over a valid/ready handshake.
- Drives memRead/memWrite/address/writeData to the byte-addressable word memory and returns load data or completion over a response handshake.
- Sub-word stores (SB/SH) use read-modify-write, because the memory only accepts full-word writes.
- Provides sign/zero extension for LB/LH/LBU/LHU and alignment checking.

Parameters:
- ADDR_W, 32, width of the byte address.
- DATA_W, 32, data width; fixed at 32, any other value is a compile-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  ADDR_W  byte address (ALU result).
- req_wdata  input  32  store data (rs2).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores.
- rsp_err  output  1  misaligned or illegal funct3.
- memRead  output  1  to memory.
- memWrite  output  1  to memory, sampled by memory on posedge clk.
- address  output  ADDR_W  to memory, always word-aligned (low 2 bits 00).
- writeData  output  32  to memory.
- readData  input  32  from memory, combinational, valid while memRead=1.

Behaviour:
- Reset (async on rst_n=0, any state): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, memRead=0, memWrite=0, address=0, writeData=0. All internal latches cleared. A request in flight is dropped with no memory write.
- memRead/memWrite/address/writeData are registered outputs (decoded from state plus latched request). memRead and memWrite are never 1 together.
- FSM states: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata, compute lane=addr[1:0], then:
  - error (misaligned or illegal) -> RESP with rsp_err=1 and no memory access;
  - load -> RD;
  - SW -> WR;
  - SB/SH -> RMW_RD.
- RD: memRead=1, address={addr[ADDR_W-1:2],2'b00}. Capture readData, extract the lane, extend (B/H sign, BU/HU zero, W as-is) -> RESP.
- WR: memWrite=1, writeData=wdata, one cycle -> RESP.
- RMW_RD: memRead=1; capture readData as old -> RMW_RW.
- RMW_WR: memWrite=1. writeData=old with the byte lane (SB: wdata[7:0] at lane*8) or halfword lane (SH: wdata[15:0] at addr[1]*16) replaced -> RESP.
- RESP: rsp_valid=1, req_ready=0. Hold rsp_rdata/rsp_err stable until rsp_ready=1, then -> IDLE. No request accepted in the same cycle as the response handshake.
- Latency, counted from req accept edge to rsp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
- Errors:
  - misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0;
  - illegal = funct3 in {011,110,111}, or store with funct3[2]=1.
- rsp_ready held 0 indefinitely: stay in RESP, outputs unchanged. The memory write already completed exactly once.

Optional Feature:
- LSU_ALIGN_CHECK_EN defined: misaligned accesses produce rsp_err=1 with no memory access, as above.
- Undefined: rsp_err=1 only for illegal funct3. Misaligned accesses proceed with forced alignment:
  - W ignores addr[1:0];
  - H/HU/SH use lane addr[1]*2 (addr[0] ignored);
  - no error is flagged.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - state enum;
  - function for the misaligned check.
- One natural sub-module, lsu_load_align: combinational lane select plus sign/zero extension (word, funct3, lane in; 32-bit out). The store merge stays inline.

Test Plan:
- Memory preloaded with word 0x8081_82F3 at 0x10; LB @0x13 -> rsp_rdata=0xFFFFFF80. LBU @0x13 -> 0x00000080. LH @0x12 -> 0xFFFF8081. LW @0x10 -> 0x808182F3. Each rsp 2 cycles after accept.
- SB 0xAB @0x11 onto 0x11223344 -> memRead cycle then memWrite with writeData=0x1122AB44. rsp_valid at cycle 3. Readback LW=0x1122AB44.
- SH 0xBEEF @0x22 onto 0x11223344 -> writeData=0xBEEF3344. SW 0xDEADBEEF @0x30 -> single memWrite, writeData=0xDEADBEEF.
- With LSU_ALIGN_CHECK_EN, LW @0x11 -> rsp_err=1 after 1 cycle, no memRead/memWrite pulse. funct3=011 -> rsp_err=1 in both builds.
- Backpressure: rsp_ready=0 for 5 cycles after a load. rsp_valid and rsp_rdata stay stable, req_ready=0, a new req_valid is not accepted. Accepted only after the handshake.
- Assert rst_n=0 during RMW_RD -> memWrite never asserts, all outputs go to reset values immediately, and the target word is unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// the access legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } lsu_state_e;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    if ((f3 == F3_H || f3 == F3_HU) && lo[0]) r = 1'b1;
    if (f3 == F3_W && lo != 2'b00)            r = 1'b1;
    return r;
  endfunction

  // Unsigned widths only exist for loads.
  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select plus sign/zero extension. Halfwords use lane[1] only, so an
// odd halfword address is force-aligned when misalignment is not trapped.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'(i_word >> {i_lane, 3'b000});
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: valid/ready request in, registered full-word memory
// strobes out, SB/SH via read-modify-write. Define LSU_ALIGN_CHECK_EN to trap
// misaligned accesses instead of force-aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  input  logic [DATA_W-1:0] readData
);

  if (DATA_W != 32) begin : g_dw_check
    $error("load_store_unit: DATA_W must be 32");
  end

  lsu_state_e        r_state, w_next;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata_lo;
  logic              r_memRead, r_memWrite, r_rsp_err;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_writeData, r_rsp_rdata;
  logic              w_accept, w_req_err, w_mem_next;
  logic [ADDR_W-1:0] w_addr_src;
  logic [DATA_W-1:0] w_load_data, w_merged;

`ifdef LSU_ALIGN_CHECK_EN
  assign w_req_err = is_illegal(req_we, req_funct3) | is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign w_req_err = is_illegal(req_we, req_funct3);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                w_next = S_RESP;
          else if (!req_we)             w_next = S_RD;
          else if (req_funct3 == F3_W)  w_next = S_WR;
          else                          w_next = S_RMW_RD;
        end
      end
      S_RD, S_WR, S_RMW_WR: w_next = S_RESP;
      S_RMW_RD:             w_next = S_RMW_WR;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept   = (r_state == S_IDLE) && req_valid;
  // The word address is registered on the accept edge, before r_addr is valid.
  assign w_addr_src = (r_state == S_IDLE) ? req_addr : r_addr;
  assign w_mem_next = (w_next == S_RD) || (w_next == S_WR) ||
                      (w_next == S_RMW_RD) || (w_next == S_RMW_WR);

  lsu_load_align u_align (
    .i_word   (readData),
    .i_funct3 (r_f3),
    .i_lane   (r_addr[1:0]),
    .o_data   (w_load_data)
  );

  // Only SB/SH reach the merge; halfword lane is addr[1] regardless of addr[0].
  always_comb begin
    w_merged = readData;
    if (r_f3 == F3_H) begin
      if (r_addr[1]) w_merged[31:16] = r_wdata_lo;
      else           w_merged[15:0]  = r_wdata_lo;
    end else begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata_lo[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f3        <= '0;
      r_addr      <= '0;
      r_wdata_lo  <= '0;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_address   <= '0;
      r_writeData <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_memRead  <= (w_next == S_RD) || (w_next == S_RMW_RD);
      r_memWrite <= (w_next == S_WR) || (w_next == S_RMW_WR);
      if (w_mem_next) r_address <= {w_addr_src[ADDR_W-1:2], 2'b00};
      if (w_accept) begin
        r_f3        <= req_funct3;
        r_addr      <= req_addr;
        r_wdata_lo  <= req_wdata[15:0];
        r_rsp_err   <= w_req_err;
        r_rsp_rdata <= '0;
      end else if (r_state == S_RD) begin
        r_rsp_rdata <= w_load_data;
      end
      if (w_accept && w_next == S_WR) r_writeData <= req_wdata;
      else if (r_state == S_RMW_RD)   r_writeData <= w_merged;
    end
  end

  assign memRead   = r_memRead;
  assign memWrite  = r_memWrite;
  assign address   = r_address;
  assign writeData = r_writeData;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-level memory reference.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        memRead, memWrite;
  logic [31:0] address, writeData, readData;

  int checks = 0;
  int errors = 0;
  int n_rd = 0;
  int n_wr = 0;

  logic [31:0] tmem    [64];
  logic [31:0] ref_mem [64];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [31:0] ld_val;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .memRead(memRead), .memWrite(memWrite), .address(address),
    .writeData(writeData), .readData(readData)
  );

  // Memory environment: combinational read, posedge full-word write.
  assign readData = tmem[address[7:2]];
  always @(posedge clk) begin
    if (memWrite) tmem[address[7:2]] <= writeData;
    if (ld_en)    tmem[ld_idx] <= ld_val;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (memRead)  n_rd++;
    if (memWrite) n_wr++;
    if (memRead || memWrite) begin
      chk("rw_excl", 32'(memRead & memWrite), 32'd0);
      chk("addr_align", 32'(address[1:0]), 32'd0);
    end
  end

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, b, h;
    w = ref_mem[a[7:2]];
    b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'h10000   : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sh;
    logic [31:0] m, v;
    if (f3 == 3'd2) begin
      ref_mem[a[7:2]] = wd;
    end else begin
      if (f3 == 3'd0) begin sh = 8 * int'(a[1:0]); m = 32'hFF << sh;   v = (wd & 32'hFF) << sh;   end
      else            begin sh = 16 * int'(a[1]);  m = 32'hFFFF << sh; v = (wd & 32'hFFFF) << sh; end
      ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~m) | v;
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    ld_idx = 6'(idx); ld_val = v; ld_en = 1'b1;
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, output logic [31:0] got);
    logic ill, mis, err;
    logic [31:0] exp_rd;
    int exp_lat, exp_r, exp_w, lat, r0, w0, idx;
    idx = int'(a[7:2]);
    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
`ifdef LSU_ALIGN_CHECK_EN
    err = ill || mis;
`else
    err = ill;
`endif
    exp_rd = 32'd0; exp_r = 0; exp_w = 0;
    if (err)             exp_lat = 1;
    else if (!we)        begin exp_lat = 2; exp_r = 1; exp_rd = ref_load(f3, a); end
    else if (f3 == 3'd2) begin exp_lat = 2; exp_w = 1; ref_store(f3, a, wd); end
    else                 begin exp_lat = 3; exp_r = 1; exp_w = 1; ref_store(f3, a, wd); end
    r0 = n_rd; w0 = n_wr;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = (hold == 0);
    lat = 0;
    while (!req_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin @(posedge clk); #1; lat++; end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", 32'(rsp_err), 32'(err));
    got = rsp_rdata;
    // Backpressure: offer a stray SW that must not be accepted.
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h3C; req_wdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
    chk("n_rd", 32'(n_rd - r0), 32'(exp_r));
    chk("n_wr", 32'(n_wr - w0), 32'(exp_w));
    if (we) chk("memword", tmem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] got;
    int w0;
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int w0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rvalid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_mrd", 32'(memRead), 32'd0);
    chk("rst_mwr", 32'(memWrite), 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_wdata", writeData, 32'd0);
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    poke(4, 32'h808182F3);
    txn(1'b0, F3_B,  32'h13, 32'd0, 0, got); chk("lb13",  got, 32'hFFFFFF80);
    txn(1'b0, F3_BU, 32'h13, 32'd0, 0, got); chk("lbu13", got, 32'h00000080);
    txn(1'b0, F3_H,  32'h12, 32'd0, 0, got); chk("lh12",  got, 32'hFFFF8081);
    txn(1'b0, F3_W,  32'h10, 32'd0, 0, got); chk("lw10",  got, 32'h808182F3);
    poke(4, 32'h11223344);
    txn(1'b1, F3_B,  32'h11, 32'h000000AB, 0, got);
    txn(1'b0, F3_W,  32'h10, 32'd0, 0, got); chk("sb_rb", got, 32'h1122AB44);
    poke(8, 32'h11223344);
    txn(1'b1, F3_H,  32'h22, 32'h0000BEEF, 0, got);
    txn(1'b0, F3_W,  32'h20, 32'd0, 0, got); chk("sh_rb", got, 32'hBEEF3344);
    txn(1'b1, F3_W,  32'h30, 32'hDEADBEEF, 0, got);
    txn(1'b0, F3_W,  32'h30, 32'd0, 0, got); chk("sw_rb", got, 32'hDEADBEEF);
    txn(1'b0, F3_W,  32'h11, 32'd0, 0, got);
    txn(1'b0, 3'd3,  32'h10, 32'd0, 0, got);
    txn(1'b1, F3_BU, 32'h10, 32'h55, 0, got);
    txn(1'b0, F3_W,  32'h10, 32'd0, 5, got); chk("bp_lw", got, 32'h1122AB44);

    // Reset while the RMW read is on the bus: the word must survive untouched.
    poke(5, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h15; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_rd_bus", 32'(memRead), 32'd1);
    w0 = n_wr;
    rst_n = 1'b0; #1;
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_rvalid", 32'(rsp_valid), 32'd0);
    chk("arst_rdata", rsp_rdata, 32'd0);
    chk("arst_err", 32'(rsp_err), 32'd0);
    chk("arst_mrd", 32'(memRead), 32'd0);
    chk("arst_mwr", 32'(memWrite), 32'd0);
    chk("arst_addr", address, 32'd0);
    chk("arst_wdata", writeData, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_nwr", 32'(n_wr - w0), 32'd0);
    chk("arst_word", tmem[5], 32'hCAFEF00D);

    for (int n = 0; n < 250; n++) begin
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] ra, rwd;
      int          rh;
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      ra  = 32'($urandom_range(0, 255));
      rwd = $urandom;
      rh  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      txn(rwe, rf3, ra, rwd, rh, got);
    end
    for (int i = 0; i < 64; i++) chk("final_mem", tmem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
